// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared register map, CTRL field positions and page modes
//               for the seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_NUM  = 2'd0;
  localparam reg_addr_t ADDR_CTRL = 2'd1;

  localparam int CTRL_GRAPH_BIT = 0;
  localparam int CTRL_PAGE_LSB  = 1;
  localparam int CTRL_PAGE_MSB  = 2;
  localparam int CTRL_PT_LSB    = 8;
  localparam int CTRL_PT_MSB    = 11;
  localparam int CTRL_BL_LSB    = 12;
  localparam int CTRL_BL_MSB    = 15;

  // Only the defined CTRL fields are stored; everything else reads back 0.
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

  typedef enum logic [1:0] {
    PAGE_LOW  = 2'd0,
    PAGE_HIGH = 2'd1,
    PAGE_AUTO = 2'd2,
    PAGE_RSVD = 2'd3
  } page_mode_e;

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl_if
// Description : CPU-side register write/read bus of the scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_ctrl_if;
  import seven_seg_pkg::*;

  logic        wr_en;
  reg_addr_t   wr_addr;
  logic [31:0] wr_data;
  reg_addr_t   rd_addr;
  logic [31:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);

endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Wrapping 0..DIV-1 counter; tick marks the enabled terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider
  import seven_seg_pkg::*;
#(
  parameter int DIV = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  output logic      tick
);

  localparam int              c_WIDTH = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(DIV - 1);

  logic [c_WIDTH-1:0] r_cnt;

  assign tick = en && (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Scan/blink/page generator for a 4-digit seven-segment display
//               with frame-synchronous commit of CPU-written registers.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125,
  parameter int PAGE_FRAMES  = 500
) (
  input  wire logic              clk,
  input  wire logic              rst,
  seven_seg_scan_ctrl_if.slave   cpu,
  output logic [31:0]            disp_num,
  output logic                   graph,
  output logic                   high_degree,
  output logic [1:0]             scanning,
  output logic [3:0]             pointing,
  output logic [3:0]             blinking,
  output logic                   flash_clk,
  output logic                   frame_tick
);

  logic        w_digit_tick;
  logic        w_frame_bound;
  logic        w_blink_wrap;
  logic        w_page_wrap;
  logic [31:0] r_num;
  logic [31:0] r_ctrl;
  logic [31:0] w_num_next;
  logic [31:0] w_ctrl_next;
  page_mode_e  w_mode_next;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (w_digit_tick)
  );

  // A frame ends when the last digit slot expires (scanning wraps 3 -> 0).
  assign w_frame_bound = w_digit_tick && (scanning == 2'd3);

  tick_divider #(.DIV(BLINK_FRAMES)) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_frame_bound),
    .tick (w_blink_wrap)
  );

  tick_divider #(.DIV(PAGE_FRAMES)) u_page_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_frame_bound),
    .tick (w_page_wrap)
  );

  // Post-write pending values, so a write on the boundary cycle joins the commit.
  always_comb begin
    w_num_next  = r_num;
    w_ctrl_next = r_ctrl;
    if (cpu.wr_en) begin
      case (cpu.wr_addr)
        ADDR_NUM:  w_num_next  = cpu.wr_data;
        ADDR_CTRL: w_ctrl_next = cpu.wr_data & CTRL_MASK;
        default:   ;
      endcase
    end
  end

  assign w_mode_next = page_mode_e'(w_ctrl_next[CTRL_PAGE_MSB:CTRL_PAGE_LSB]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_ctrl      <= '0;
      cpu.rd_data <= '0;
      disp_num    <= '0;
      graph       <= 1'b0;
      high_degree <= 1'b0;
      scanning    <= 2'd0;
      pointing    <= 4'd0;
      blinking    <= 4'd0;
      flash_clk   <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      r_num      <= w_num_next;
      r_ctrl     <= w_ctrl_next;
      frame_tick <= w_frame_bound;

      case (cpu.rd_addr)
        ADDR_NUM:  cpu.rd_data <= r_num;
        ADDR_CTRL: cpu.rd_data <= r_ctrl;
        default:   cpu.rd_data <= '0;
      endcase

      if (w_digit_tick) begin
        scanning <= scanning + 2'd1;
      end

      if (w_frame_bound) begin
        disp_num <= w_num_next;
        graph    <= w_ctrl_next[CTRL_GRAPH_BIT];
        pointing <= w_ctrl_next[CTRL_PT_MSB:CTRL_PT_LSB];
        blinking <= w_ctrl_next[CTRL_BL_MSB:CTRL_BL_LSB];
        if (w_blink_wrap) begin
          flash_clk <= ~flash_clk;
        end
        // Auto mode keeps whatever page was showing and flips on page wrap.
        case (w_mode_next)
          PAGE_HIGH: high_degree <= 1'b1;
          PAGE_AUTO: if (w_page_wrap) high_degree <= ~high_degree;
          default:   high_degree <= 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Directed bench with a frame-level commit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int SCAN_DIV     = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int PAGE_FRAMES  = 3;

  typedef struct {
    logic [31:0] num;
    logic        graph;
    logic [3:0]  pt;
    logic [3:0]  bl;
    logic        hd;
    logic        fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_num;
  logic        graph;
  logic        high_degree;
  logic [1:0]  scanning;
  logic [3:0]  pointing;
  logic [3:0]  blinking;
  logic        flash_clk;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  exp_t        sb_q[$];
  logic [31:0] m_num = '0;
  logic [31:0] m_ctrl = '0;
  logic [31:0] m_disp = '0;
  logic        m_flash = 1'b0;
  logic        m_hd = 1'b0;
  int          m_blink = 0;
  int          m_page = 0;

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .PAGE_FRAMES  (PAGE_FRAMES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (bus),
    .disp_num    (disp_num),
    .graph       (graph),
    .high_degree (high_degree),
    .scanning    (scanning),
    .pointing    (pointing),
    .blinking    (blinking),
    .flash_clk   (flash_clk),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    if (addr == 2'd0) m_num = data;
    else if (addr == 2'd1) m_ctrl = data & 32'h0000_FF07;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Predicts one commit from the pending model and the frame-rate counters.
  task automatic predict_frame();
    exp_t e;
    logic wrap;
    m_blink++;
    if (m_blink == BLINK_FRAMES) begin
      m_blink = 0;
      m_flash = ~m_flash;
    end
    m_page++;
    wrap = (m_page == PAGE_FRAMES);
    if (wrap) m_page = 0;
    case (m_ctrl[2:1])
      2'd1:    m_hd = 1'b1;
      2'd2:    if (wrap) m_hd = ~m_hd;
      default: m_hd = 1'b0;
    endcase
    m_disp   = m_num;
    e.num    = m_num;
    e.graph  = m_ctrl[0];
    e.pt     = m_ctrl[11:8];
    e.bl     = m_ctrl[15:12];
    e.hd     = m_hd;
    e.fl     = m_flash;
    sb_q.push_back(e);
  endtask

  task automatic compare_commit();
    exp_t e;
    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("disp_num", disp_num, e.num);
      check("graph", 32'(graph), 32'(e.graph));
      check("pointing", 32'(pointing), 32'(e.pt));
      check("blinking", 32'(blinking), 32'(e.bl));
      check("high_degree", 32'(high_degree), 32'(e.hd));
      check("flash_clk", 32'(flash_clk), 32'(e.fl));
    end
  endtask

  // Waits (bounded) for the next commit, checks it, and leaves the bench one
  // cycle after the frame_tick cycle.
  task automatic wait_commit();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("frame_tick_seen", 32'(frame_tick), 32'd1);
    check("scan_at_commit", 32'(scanning), 32'd0);
    compare_commit();
    tick();
    check("frame_tick_pulse", 32'(frame_tick), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp"}, disp_num, 32'd0);
    check({tag, "_misc"}, {20'd0, graph, high_degree, scanning, pointing, blinking, flash_clk, frame_tick}, 32'd0);
    check({tag, "_rd"}, bus.rd_data, 32'd0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = '0;
    bus.rd_addr = 2'd0;

    // Reset, then free run: two commits at cycles 8 and 16.
    repeat (3) tick();
    rst = 1'b0;
    check_all_zero("reset");
    predict_frame();
    predict_frame();
    for (int i = 0; i <= 16; i++) begin
      check("scan_seq", 32'(scanning), 32'((i / 2) % 4));
      check("ft_seq", 32'(frame_tick), 32'((i == 8) || (i == 16)));
      if (i == 8 || i == 16) compare_commit();
      tick();
    end

    // Mid-frame NUM write: pending readback next cycle, display waits for commit.
    bus.rd_addr = 2'd0;
    write(2'd0, 32'h1234_ABCD);
    tick();
    check("rd_num", bus.rd_data, 32'h1234_ABCD);
    check("disp_held", disp_num, m_disp);
    predict_frame();
    wait_commit();

    // Write landing exactly on the frame-boundary cycle (T+7 from frame_tick).
    repeat (6) tick();
    write(2'd0, 32'h0000_0005);
    predict_frame();
    wait_commit();

    // Last write in a frame wins.
    write(2'd0, 32'h0000_0006);
    write(2'd0, 32'h0000_0007);
    predict_frame();
    wait_commit();

    // Blink phase over four frames.
    for (int f = 0; f < 4; f++) begin
      predict_frame();
      wait_commit();
    end

    // CTRL auto page mode with pointing/blinking fields.
    bus.rd_addr = 2'd1;
    write(2'd1, 32'h0000_A504);
    tick();
    check("rd_ctrl", bus.rd_data, 32'h0000_A504);
    predict_frame();
    wait_commit();
    for (int f = 0; f < 6; f++) begin
      predict_frame();
      wait_commit();
    end

    // Fixed high page; undefined CTRL bits read back as 0; addr 2 reads 0.
    write(2'd1, 32'hFFFF_A502);
    tick();
    check("rd_ctrl_mask", bus.rd_data, 32'h0000_A502);
    bus.rd_addr = 2'd2;
    tick();
    check("rd_addr2", bus.rd_data, 32'd0);
    predict_frame();
    wait_commit();
    predict_frame();
    wait_commit();

    // Mid-frame reset discards pending writes and all state.
    write(2'd0, 32'hDEAD_BEEF);
    write(2'd1, 32'h0000_F105);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    m_num = '0; m_ctrl = '0; m_disp = '0;
    m_flash = 1'b0; m_hd = 1'b0; m_blink = 0; m_page = 0;
    sb_q.delete();
    bus.rd_addr = 2'd0;
    tick();
    check("rst_rd_num", bus.rd_data, 32'd0);
    bus.rd_addr = 2'd1;
    tick();
    check("rst_rd_ctrl", bus.rd_data, 32'd0);
    predict_frame();
    wait_commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Upstream driver for the 4-digit seven-segment display device; generates every input that device consumes: scanning index, flash_clk, disp_num, graph, high_degree, pointing, blinking.
- Holds a small CPU-writable register file (pending copy) and commits it to the display outputs only at frame boundaries, so a digit scan never shows a partly updated value.
- Sits between the CPU bus/IO decoder and the display device on the board top level.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range >= 1.
- BLINK_FRAMES, 125, frames per flash_clk half-period; legal range >= 1.
- PAGE_FRAMES, 500, frames per high_degree toggle in auto page mode; legal range >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  2  write address: 0 = NUM, 1 = CTRL; 2 and 3 are ignored.
- wr_data  in  32  write data.
- rd_addr  in  2  read address.
- rd_data  out  32  pending register contents, registered.
- disp_num  out  32  committed number.
- graph  out  1  committed CTRL[0].
- high_degree  out  1  page select: low half or high half of disp_num.
- scanning  out  2  active digit index, 0..3.
- pointing  out  4  committed CTRL[11:8], decimal point per digit.
- blinking  out  4  committed CTRL[15:12], blink enable per digit.
- flash_clk  out  1  blink phase, square wave.
- frame_tick  out  1  one-cycle pulse on each commit.

Behaviour:
- Reset values: all outputs 0; pending NUM = 0; pending CTRL = 0; all counters = 0.
- CTRL fields: [0] graph; [2:1] page_mode (0 = fixed low, 1 = fixed high, 2 = auto, 3 = treated as 0); [11:8] pointing; [15:12] blinking; other bits read back as 0.
- Prescaler:
  - counts 0..SCAN_DIV-1; digit_tick asserts when it equals SCAN_DIV-1, then it wraps to 0.
  - on digit_tick, scanning increments mod 4.
  - scanning is registered and changes in the cycle after digit_tick.
- Frame boundary:
  - occurs when digit_tick fires while scanning == 3, i.e. scanning 3 -> 0.
  - in the next cycle: committed regs <= pending regs; frame_tick = 1 for exactly one cycle.
  - scanning therefore reads 0 in the same cycle the new committed values become visible.
- Writes:
  - wr_en with wr_addr 0/1 updates the pending reg on the next edge.
  - a write in the same cycle as the frame boundary is included in that commit (commit takes the post-write next value).
  - multiple writes within one frame: the last one wins.
- Blink:
  - frame counter counts 0..BLINK_FRAMES-1, advancing on frame boundaries.
  - on wrap, flash_clk toggles.
  - blink counter and flash_clk are never cleared by writes.
- Page:
  - page counter counts 0..PAGE_FRAMES-1, advancing on frame boundaries.
  - committed page_mode 0 -> high_degree = 0; 1 -> high_degree = 1; 2 -> high_degree toggles on page-counter wrap.
  - entering mode 2 starts from the current high_degree value.
  - the page counter runs in all modes.
- rd_data: one-cycle latency from rd_addr; addresses 2/3 read 0.
- SCAN_DIV = 1: digit_tick every cycle, scanning advances every cycle, frame boundary every 4 cycles.
- Counter widths: $clog2 of each parameter, minimum 1 bit; no overflow beyond the terminal count.
- rst mid-frame: everything returns to reset values in the next cycle and the pending writes are lost.

Decomposition:
- Shared package seven_seg_pkg:
  - register address constants ADDR_NUM = 0 and ADDR_CTRL = 1.
  - CTRL field bit positions.
  - page_mode encodings PAGE_LOW, PAGE_HIGH, PAGE_AUTO.
- One natural sub-module: tick_divider.
  - parameter DIV; inputs clk, rst, en; output tick; wrapping counter.
  - instantiated three times: digit prescaler (en = 1), blink counter (en = frame boundary), page counter (en = frame boundary).

Test Plan (SCAN_DIV = 2, BLINK_FRAMES = 2, PAGE_FRAMES = 3):
- Reset, then free run 16 cycles -> scanning sequence 0,0,1,1,2,2,3,3,0,... with rst released at cycle 0; frame_tick pulses every 8 cycles, coincident with scanning returning to 0; all other outputs 0.
- Write NUM = 32'h1234ABCD mid-frame -> disp_num stays 0 until the next frame_tick cycle, then equals 32'h1234ABCD; rd_data(addr 0) shows the value one cycle after the write.
- Write NUM = 32'h0000_0005 in the exact frame-boundary cycle -> disp_num = 5 in the frame_tick cycle; two writes (6, then 7) within one frame -> only 7 is committed.
- Run 4 frames -> flash_clk = 0,0,1,1,0 at successive frame_tick cycles, toggling every 2 frames.
- CTRL = 32'h0000_A504 (page_mode 2, pointing 5, blinking A) -> after commit, pointing = 4'h5 and blinking = 4'hA; high_degree toggles every 3 frames; then CTRL page_mode 1 -> high_degree = 1 from the next commit.
- Assert rst for 1 cycle mid-frame with pending writes -> next cycle all outputs 0; rd_data reads 0 for both addresses; scanning restarts at 0.
